imem_server: RTL and testbench

Instruction-memory responder for the fetch stage: it receives the fetch address and returns the instruction word one cycle later. It also owns a byte-stream program loader that fills the memory after reset or on request, and it holds the fetch stage stalled while loading. It sits between the fetch stage and the external loader link (UART or debug bridge).

---
 rtl/imem_server_pkg.sv | 13 +
 rtl/imem_server_if.sv | 36 +++
 rtl/imem_ram.sv | 32 +++
 rtl/imem_server.sv | 122 ++++++++++++
 tb/tb_imem_server.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/imem_server_pkg.sv
// rtl/imem_server_pkg.sv - shared constants and FSM encoding for the instruction-memory server
package imem_server_pkg;
    localparam int WORD = 32;
    localparam int ADDR = 16;
    localparam logic [WORD-1:0] NOP_INST = 32'h0000_0000;
    localparam int BYTES_PER_WORD = WORD / 8;
    localparam int BCNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef enum logic {
        IMEM_LOAD = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_e;
endpackage

// File: rtl/imem_server_if.sv
// rtl/imem_server_if.sv - fetch and loader signals of imem_server; fault_o only with IMEM_OOR_TRAP_EN
interface imem_server_if #(
    parameter int DEPTH_LOG2 = 10
) ();
    import imem_server_pkg::*;

    logic [ADDR-1:0]       addr_i;
    logic [WORD-1:0]       inst_o;
    logic                  stall_o;
    logic                  load_start_i;
    logic [7:0]            ld_data_i;
    logic                  ld_valid_i;
    logic                  ld_last_i;
    logic                  ld_ready_o;
    logic [DEPTH_LOG2:0]   ld_words_o;
    logic                  overflow_o;
`ifdef IMEM_OOR_TRAP_EN
    logic                  fault_o;
`endif

    modport master (
        output addr_i, load_start_i, ld_data_i, ld_valid_i, ld_last_i,
`ifdef IMEM_OOR_TRAP_EN
        input  fault_o,
`endif
        input  inst_o, stall_o, ld_ready_o, ld_words_o, overflow_o
    );

    modport slave (
        input  addr_i, load_start_i, ld_data_i, ld_valid_i, ld_last_i,
`ifdef IMEM_OOR_TRAP_EN
        output fault_o,
`endif
        output inst_o, stall_o, ld_ready_o, ld_words_o, overflow_o
    );
endinterface

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - synchronous RAM with registered read address; a same-edge write is seen by the read (write-first)
module imem_ram #(
    parameter int WIDTH = 32,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [2**AW];
    logic [AW-1:0]    raddr_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_q <= '0;
        end else begin
            raddr_q <= raddr_i;
        end
    end

    assign rdata_o = mem_q[raddr_q];
endmodule

// File: rtl/imem_server.sv
// rtl/imem_server.sv - fetch responder with byte-stream program loader; IMEM_OOR_TRAP_EN adds the out-of-range trap
module imem_server
    import imem_server_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input logic           clk,
    input logic           rst,
    imem_server_if.slave  bus
);
    imem_state_e           state_q;
    logic                  stall_q;
    logic                  ready_q;
    logic                  ovf_q;
    logic [DEPTH_LOG2:0]   wptr_q;
    logic [WORD-1:0]       asm_q;
    logic [WORD-1:0]       asm_d;
    logic [BCNT_W-1:0]     bcnt_q;
    logic                  accept;
    logic                  word_done;
    logic                  mem_full;
    logic                  we;
    logic [WORD-1:0]       rdata;

    // asm_q is cleared after every word, so a short final word is already zero-padded
    always_comb begin
        asm_d = asm_q;
        asm_d[bcnt_q*8 +: 8] = bus.ld_data_i;
    end

    assign accept    = (state_q == IMEM_LOAD) && bus.ld_valid_i;
    assign word_done = accept && ((bcnt_q == BCNT_W'(BYTES_PER_WORD - 1)) || bus.ld_last_i);
    assign mem_full  = wptr_q[DEPTH_LOG2];
    assign we        = word_done && !mem_full;

    imem_ram #(
        .WIDTH (WORD),
        .AW    (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (wptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (asm_d),
        .raddr_i (bus.addr_i[DEPTH_LOG2-1:0]),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IMEM_LOAD;
            stall_q <= 1'b1;
            ready_q <= 1'b1;
            wptr_q  <= '0;
            asm_q   <= '0;
            bcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IMEM_LOAD: begin
                    if (accept) begin
                        if (word_done) begin
                            asm_q  <= '0;
                            bcnt_q <= '0;
                            if (mem_full) begin
                                ovf_q <= 1'b1;
                            end else begin
                                wptr_q <= wptr_q + 1'b1;
                            end
                        end else begin
                            asm_q  <= asm_d;
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                        if (bus.ld_last_i) begin
                            state_q <= IMEM_RUN;
                            stall_q <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    end
                end
                IMEM_RUN: begin
                    if (bus.load_start_i) begin
                        state_q <= IMEM_LOAD;
                        stall_q <= 1'b1;
                        ready_q <= 1'b1;
                        wptr_q  <= '0;
                        asm_q   <= '0;
                        bcnt_q  <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef IMEM_OOR_TRAP_EN
    logic fault_q;
    logic oor;

    assign oor = (bus.addr_i >> DEPTH_LOG2) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_q == IMEM_RUN) && !bus.load_start_i && oor;
        end
    end

    assign bus.fault_o = fault_q;
    assign bus.inst_o  = (state_q == IMEM_RUN && !fault_q) ? rdata : NOP_INST;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |(bus.addr_i >> DEPTH_LOG2);
    assign bus.inst_o     = (state_q == IMEM_RUN) ? rdata : NOP_INST;
`endif

    assign bus.stall_o    = stall_q;
    assign bus.ld_ready_o = ready_q;
    assign bus.ld_words_o = wptr_q;
    assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_imem_server.sv
// tb/tb_imem_server.sv - randomized bench for imem_server against a byte-queue memory model
module tb_imem_server;
    import imem_server_pkg::*;

    localparam int D     = 2;
    localparam int DEPTH = 2**D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_server_if #(.DEPTH_LOG2(D)) bus ();
    imem_server #(.DEPTH_LOG2(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: memory as a word array, the word under assembly as a byte queue
    logic [31:0]  m_mem [DEPTH];
    bit           m_known [DEPTH];
    byte unsigned m_bytes [$];
    bit           m_loading = 1'b1;
    int           m_words   = 0;
    bit           m_ovf     = 1'b0;
    int           m_addr    = 0;
    bit           m_fault   = 1'b0;

    always begin
        bit           s_rst, s_v, s_l, s_ls, was_run;
        byte unsigned s_d;
        int           s_a;
        logic [31:0]  w;
        @(posedge clk);
        s_rst = rst; s_v = bus.ld_valid_i; s_l = bus.ld_last_i; s_ls = bus.load_start_i;
        s_d = bus.ld_data_i; s_a = int'(bus.addr_i);
        if (s_rst) begin
            m_loading = 1'b1; m_bytes.delete(); m_words = 0; m_ovf = 1'b0; m_addr = 0; m_fault = 1'b0;
        end else begin
            was_run = !m_loading;
            m_fault = 1'b0;
            if (m_loading) begin
                if (s_v) begin
                    m_bytes.push_back(s_d);
                    if (m_bytes.size() == BYTES_PER_WORD || s_l) begin
                        w = '0;
                        foreach (m_bytes[i]) w |= 32'(m_bytes[i]) << (8 * i);
                        if (m_words < DEPTH) begin
                            m_mem[m_words] = w; m_known[m_words] = 1'b1; m_words++;
                        end else begin
                            m_ovf = 1'b1;
                        end
                        m_bytes.delete();
                    end
                    if (s_l) m_loading = 1'b0;
                end
            end else if (s_ls) begin
                m_loading = 1'b1; m_words = 0; m_ovf = 1'b0; m_bytes.delete();
            end
`ifdef IMEM_OOR_TRAP_EN
            if (was_run && !s_ls && s_a >= DEPTH) m_fault = 1'b1;
`else
            if (was_run && s_a < 0) m_fault = 1'b0;
`endif
            m_addr = s_a % DEPTH;
        end
        #1;
        chk("stall", 32'(bus.stall_o), 32'(m_loading));
        chk("ready", 32'(bus.ld_ready_o), 32'(m_loading));
        chk("words", 32'(bus.ld_words_o), 32'(m_words));
        chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
`ifdef IMEM_OOR_TRAP_EN
        chk("fault", 32'(bus.fault_o), 32'(m_fault));
`endif
        if (m_loading || m_fault) chk("inst_nop", bus.inst_o, NOP_INST);
        else if (m_known[m_addr]) chk("inst", bus.inst_o, m_mem[m_addr]);
    end

    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit ls, input logic [15:0] a);
        @(negedge clk);
        bus.ld_valid_i = v; bus.ld_data_i = d; bus.ld_last_i = l;
        bus.load_start_i = ls; bus.addr_i = a;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_stall", 32'(bus.stall_o), 32'd1);
        chk("rst_ready", 32'(bus.ld_ready_o), 32'd1);
        chk("rst_words", 32'(bus.ld_words_o), 32'd0);
        chk("rst_ovf", 32'(bus.overflow_o), 32'd0);
        chk("rst_inst", bus.inst_o, NOP_INST);
`ifdef IMEM_OOR_TRAP_EN
        chk("rst_fault", 32'(bus.fault_o), 32'd0);
`endif
    endtask

    logic [31:0] ow [6];

    initial begin
        logic [7:0] b;
        int nb, nrun;
        bus.ld_valid_i = 1'b0; bus.ld_data_i = '0; bus.ld_last_i = 1'b0;
        bus.load_start_i = 1'b0; bus.addr_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 chk_reset_vals();

        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 * (i + 1)), i == 7, 1'b0, 16'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'd0); settle();
        chk("t1_words", 32'(bus.ld_words_o), 32'd2);
        chk("t1_stall", 32'(bus.stall_o), 32'd0);
        chk("t1_word0", bus.inst_o, 32'h4433_2211);
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'd1); settle();
        chk("t1_word1", bus.inst_o, 32'h8877_6655);

        step(1'b0, 8'h00, 1'b0, 1'b1, 16'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 16'd1); settle();
            chk("idle_stall", 32'(bus.stall_o), 32'd1);
            chk("idle_inst", bus.inst_o, NOP_INST);
        end
        for (int i = 0; i < 5; i++) step(1'b1, (i == 4) ? 8'hAB : 8'(i + 1), i == 4, 1'b0, 16'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'd1); settle();
        chk("t2_word1", bus.inst_o, 32'h0000_00AB);
        chk("t2_words", 32'(bus.ld_words_o), 32'd2);

        step(1'b0, 8'h00, 1'b0, 1'b1, 16'd0);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 16'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'd0); settle();
        chk("t3_word0", bus.inst_o, 32'h0000_005A);
        chk("t3_words", 32'(bus.ld_words_o), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'd1); settle();
        chk("t3_kept", bus.inst_o, 32'h0000_00AB);

        step(1'b0, 8'h00, 1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            ow[i/4][8*(i%4) +: 8] = b;
            step(1'b1, b, i == 23, 1'b0, 16'd0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'd0); settle();
        chk("ov_words", 32'(bus.ld_words_o), 32'd4);
        chk("ov_flag", 32'(bus.overflow_o), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 16'(k)); settle();
            chk("ov_intact", bus.inst_o, ow[k]);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'h0400); settle();
`ifdef IMEM_OOR_TRAP_EN
        chk("trap_inst", bus.inst_o, NOP_INST);
        chk("trap_fault", 32'(bus.fault_o), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'd0); settle();
        chk("trap_clear", 32'(bus.fault_o), 32'd0);
`else
        chk("wrap_inst", bus.inst_o, ow[0]);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1, 16'd0); settle();
        chk("reload_ovf", 32'(bus.overflow_o), 32'd0);
        chk("reload_words", 32'(bus.ld_words_o), 32'd0);

        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC1 + i), 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        bus.ld_valid_i = 1'b0; rst = 1'b1;
        #1 chk_reset_vals();
        @(negedge clk); rst = 1'b0;
        step(1'b1, 8'h77, 1'b1, 1'b0, 16'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'd1); settle();
        chk("mid_rst_word1", bus.inst_o, ow[1]);

        for (int it = 0; it < 40; it++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, 16'($urandom_range(0, 7)));
            nb = $urandom_range(1, 24);
            for (int i = 0; i < nb; i++) begin
                while ($urandom_range(0, 3) == 0)
                    step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
                step(1'b1, 8'($urandom), i == nb - 1, 1'($urandom_range(0, 4) == 0), 16'($urandom_range(0, 7)));
            end
            nrun = $urandom_range(3, 15);
            for (int i = 0; i < nrun; i++)
                step(1'($urandom), 8'($urandom), 1'($urandom), 1'b0,
                     ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7)));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'd0); settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
